// File: rtl/fft_radix2_iter.sv
// rtl/fft_radix2_iter.sv - iterative in-place radix-2 DIT FFT, one butterfly every 4 cycles
// Build option FFT_STAGE_SCALE_EN: halve every stage (output = DFT/N) instead of saturating.
module fft_radix2_iter #(
   parameter int SAMPLE_WORD_LENGTH   = 8,
   parameter int SAMPLE_FLOAT_LENGTH  = 7,
   parameter int TWIDDLE_WORD_LENGTH  = 8,
   parameter int TWIDDLE_FLOAT_LENGTH = 7,
   parameter int LOG2_POINTS          = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [SAMPLE_WORD_LENGTH-1:0]  din_i,
   input  logic [SAMPLE_WORD_LENGTH-1:0]  din_q,
   input  logic                           din_valid,
   output logic                           din_ready,
   output logic [SAMPLE_WORD_LENGTH-1:0]  dout_i,
   output logic [SAMPLE_WORD_LENGTH-1:0]  dout_q,
   output logic                           dout_valid,
   input  logic                           dout_ready,
   output logic                           dout_last,
   output logic [LOG2_POINTS-2:0]         tw_addr,
   input  logic [TWIDDLE_WORD_LENGTH-1:0] tw_i,
   input  logic [TWIDDLE_WORD_LENGTH-1:0] tw_q,
   output logic                           busy,
   output logic                           ovf
);
   localparam int W = SAMPLE_WORD_LENGTH;
   localparam int L = LOG2_POINTS;
   localparam int N = 1 << L;
   localparam int KW = L - 1;
   localparam int PW = W + TWIDDLE_WORD_LENGTH + 1;
   localparam int SW = PW + 1;
   // Product carries sample+twiddle fraction bits; drop the twiddle ones to return to sample format.
   localparam int PROD_FRAC = SAMPLE_FLOAT_LENGTH + TWIDDLE_FLOAT_LENGTH;
   localparam int RSHIFT = PROD_FRAC - SAMPLE_FLOAT_LENGTH;
   localparam logic signed [PW-1:0] RND = PW'(2 ** (RSHIFT - 1));
   localparam logic signed [SW-1:0] SMAX = SW'(2 ** (W - 1) - 1);
   localparam logic signed [SW-1:0] SMIN = SW'(-(2 ** (W - 1)));

   typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

   state_t              state;
   logic [W-1:0]        mem_i [N];
   logic [W-1:0]        mem_q [N];
   logic [L-1:0]        cnt;
   logic [L-1:0]        out_idx;
   logic [3:0]          stage;
   logic [L-2:0]        bfly;
   logic [1:0]          phase;
   logic signed [W-1:0] a_i, a_q, b_i, b_q;
   logic signed [PW-1:0] bw_i, bw_q;

   logic [L-1:0]         j_ext, half, a_idx, b_idx;
   logic [3:0]           k_shift;
   logic [L-2:0]         k;
   logic signed [PW-1:0] bi, bq, wi, wq, rnd_i, rnd_q;
   logic signed [SW-1:0] sa_i, sa_q, sb_i, sb_q;
   logic [W-1:0]         ra_i, ra_q, rb_i, rb_q;
   logic                 any_sat;

   function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
      logic [L-1:0] r;
      for (int b = 0; b < L; b++) r[b] = v[L-1-b];
      return r;
   endfunction

   function automatic logic [W-1:0] sat(input logic signed [SW-1:0] x);
      if (x > SMAX) return SMAX[W-1:0];
      if (x < SMIN) return SMIN[W-1:0];
      return x[W-1:0];
   endfunction

`ifdef FFT_STAGE_SCALE_EN
   function automatic logic [W-1:0] reduce(input logic signed [SW-1:0] x);
      return sat((x + SW'(1)) >>> 1);
   endfunction
`else
   function automatic logic [W-1:0] reduce(input logic signed [SW-1:0] x);
      return sat(x);
   endfunction

   function automatic logic clipped(input logic signed [SW-1:0] x);
      return (x > SMAX) || (x < SMIN);
   endfunction
`endif

   always_comb begin
      j_ext   = {1'b0, bfly};
      half    = L'(1) << stage;
      a_idx   = ((j_ext >> stage) << (stage + 4'd1)) | (j_ext & (half - L'(1)));
      b_idx   = a_idx | half;
      k_shift = 4'(L - 1) - stage;
      k       = KW'((j_ext & (half - L'(1))) << k_shift);

      bi    = PW'(b_i);
      bq    = PW'(b_q);
      wi    = PW'($signed(tw_i));
      wq    = PW'($signed(tw_q));
      rnd_i = (bi * wi - bq * wq + RND) >>> RSHIFT;
      rnd_q = (bi * wq + bq * wi + RND) >>> RSHIFT;

      sa_i = SW'(a_i) + SW'(bw_i);
      sa_q = SW'(a_q) + SW'(bw_q);
      sb_i = SW'(a_i) - SW'(bw_i);
      sb_q = SW'(a_q) - SW'(bw_q);
      ra_i = reduce(sa_i);
      ra_q = reduce(sa_q);
      rb_i = reduce(sb_i);
      rb_q = reduce(sb_q);
`ifdef FFT_STAGE_SCALE_EN
      any_sat = 1'b0;
`else
      any_sat = clipped(sa_i) | clipped(sa_q) | clipped(sb_i) | clipped(sb_q);
`endif
   end

   // Sample memory is deliberately not reset; UNLOAD is only reachable after a full LOAD.
   always_ff @(posedge clk) begin
      if (din_valid && din_ready) begin
         mem_i[bitrev(cnt)] <= din_i;
         mem_q[bitrev(cnt)] <= din_q;
      end
      if (state == COMPUTE && phase == 2'd3) begin
         mem_i[a_idx] <= ra_i;
         mem_q[a_idx] <= ra_q;
         mem_i[b_idx] <= rb_i;
         mem_q[b_idx] <= rb_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= LOAD;
         din_ready  <= 1'b1;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         dout_i     <= '0;
         dout_q     <= '0;
         busy       <= 1'b0;
         ovf        <= 1'b0;
         tw_addr    <= '0;
         cnt        <= '0;
         out_idx    <= '0;
         stage      <= '0;
         bfly       <= '0;
         phase      <= '0;
         a_i        <= '0;
         a_q        <= '0;
         b_i        <= '0;
         b_q        <= '0;
         bw_i       <= '0;
         bw_q       <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (din_valid) begin
                  busy <= 1'b1;
                  if (cnt == '0) ovf <= 1'b0;
                  cnt <= cnt + L'(1);
                  if (cnt == L'(N - 1)) begin
                     state     <= COMPUTE;
                     din_ready <= 1'b0;
                     stage     <= '0;
                     bfly      <= '0;
                     phase     <= '0;
                  end
               end
            end
            COMPUTE: begin
               phase <= phase + 2'd1;
               case (phase)
                  2'd0: begin
                     a_i     <= mem_i[a_idx];
                     a_q     <= mem_q[a_idx];
                     tw_addr <= k;
                  end
                  2'd1: begin
                     b_i <= mem_i[b_idx];
                     b_q <= mem_q[b_idx];
                  end
                  2'd2: begin
                     bw_i <= rnd_i;
                     bw_q <= rnd_q;
                  end
                  default: begin
                     if (any_sat) ovf <= 1'b1;
                     if (bfly == '1) begin
                        bfly <= '0;
                        if (stage == 4'(L - 1)) begin
                           // Bin 0 was finalised by the first butterfly of the last stage, so present it now.
                           state      <= UNLOAD;
                           stage      <= '0;
                           dout_i     <= mem_i[{L{1'b0}}];
                           dout_q     <= mem_q[{L{1'b0}}];
                           dout_valid <= 1'b1;
                           dout_last  <= 1'b0;
                           out_idx    <= L'(1);
                        end else begin
                           stage <= stage + 4'd1;
                        end
                     end else begin
                        bfly <= bfly + 1'b1;
                     end
                  end
               endcase
            end
            UNLOAD: begin
               if (dout_ready) begin
                  if (dout_last) begin
                     state      <= LOAD;
                     dout_valid <= 1'b0;
                     dout_last  <= 1'b0;
                     busy       <= 1'b0;
                     din_ready  <= 1'b1;
                     cnt        <= '0;
                  end else begin
                     dout_i    <= mem_i[out_idx];
                     dout_q    <= mem_q[out_idx];
                     dout_last <= (out_idx == L'(N - 1));
                     out_idx   <= out_idx + L'(1);
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_radix2_iter.sv
// tb/tb_fft_radix2_iter.sv - self-checking bench for fft_radix2_iter (N=16) against an integer FFT model
module tb_fft_radix2_iter;
   localparam int W  = 8;
   localparam int TW = 8;
   localparam int TF = 7;
   localparam int L  = 4;
   localparam int N  = 16;
`ifdef FFT_STAGE_SCALE_EN
   localparam int IMP_BIN = 4;
   localparam int DC_BIN0 = 8;
   localparam int DC_OVF  = 0;
`else
   localparam int IMP_BIN = 64;
   localparam int DC_BIN0 = 127;
   localparam int DC_OVF  = 1;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  din_i, din_q;
   logic          din_valid, din_ready;
   logic [W-1:0]  dout_i, dout_q;
   logic          dout_valid, dout_ready, dout_last;
   logic [L-2:0]  tw_addr;
   logic [TW-1:0] tw_i, tw_q;
   logic          busy, ovf;

   int passed = 0;
   int failed = 0;
   int total  = 0;
   int xi[N], xq[N], ei[N], eq[N], oi[N], oq[N];
   int rom_i[N/2], rom_q[N/2];
   bit e_ovf = 1'b0;

   fft_radix2_iter #(
      .SAMPLE_WORD_LENGTH(W), .SAMPLE_FLOAT_LENGTH(7),
      .TWIDDLE_WORD_LENGTH(TW), .TWIDDLE_FLOAT_LENGTH(TF), .LOG2_POINTS(L)
   ) dut (
      .clk(clk), .rst(rst),
      .din_i(din_i), .din_q(din_q), .din_valid(din_valid), .din_ready(din_ready),
      .dout_i(dout_i), .dout_q(dout_q), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_last(dout_last), .tw_addr(tw_addr), .tw_i(tw_i), .tw_q(tw_q),
      .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Twiddle ROM with one cycle of read latency.
   always @(posedge clk) begin
      tw_i <= TW'(rom_i[tw_addr]);
      tw_q <= TW'(rom_q[tw_addr]);
   end

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clamp8(input int v);
      return (v > 127) ? 127 : ((v < -128) ? -128 : v);
   endfunction

   function automatic int reduce(input int v);
      int x = v;
`ifdef FFT_STAGE_SCALE_EN
      x = (x + 1) >>> 1;
`endif
      if (x > 127 || x < -128) begin
`ifndef FFT_STAGE_SCALE_EN
         e_ovf = 1'b1;
`endif
         x = clamp8(x);
      end
      return x;
   endfunction

   // Reference: bit-reversed load, then textbook in-place DIT stages in integer arithmetic.
   task automatic run_model();
      int ai[N], aq[N];
      e_ovf = 1'b0;
      for (int n = 0; n < N; n++) begin
         int r = 0;
         for (int b = 0; b < L; b++) if (((n >> b) & 1) == 1) r += 1 << (L - 1 - b);
         ai[r] = xi[n];
         aq[r] = xq[n];
      end
      for (int s = 0; s < L; s++) begin
         for (int j = 0; j < N / 2; j++) begin
            int h   = 1 << s;
            int a   = (j / h) * 2 * h + j % h;
            int b   = a + h;
            int k   = (j % h) * (1 << (L - 1 - s));
            int bwi = (ai[b] * rom_i[k] - aq[b] * rom_q[k] + (1 << (TF - 1))) >>> TF;
            int bwq = (ai[b] * rom_q[k] + aq[b] * rom_i[k] + (1 << (TF - 1))) >>> TF;
            int ta  = ai[a];
            int tq  = aq[a];
            ai[a] = reduce(ta + bwi);
            aq[a] = reduce(tq + bwq);
            ai[b] = reduce(ta - bwi);
            aq[b] = reduce(tq - bwq);
         end
      end
      ei = ai;
      eq = aq;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      din_valid = 1'b0;
      dout_ready = 1'b0;
      e_ovf = 1'b0;
      #2;
      check("rst_din_ready", din_ready, 1);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_dout_last", dout_last, 0);
      check("rst_dout_i", dout_i, 0);
      check("rst_dout_q", dout_q, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", ovf, 0);
      check("rst_tw_addr", tw_addr, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic load_frame(input bit hold_valid);
      int n = 0;
      int guard = 0;
      check("ovf_held", ovf, e_ovf);
      check("busy_idle", busy, 0);
      while (n < N && guard < 500) begin
         bit rdy;
         if ($urandom_range(3) == 0) begin
            din_valid = 1'b0;
            din_i = W'($urandom);
            din_q = W'($urandom);
            @(posedge clk); #1;
            guard++;
         end
         din_valid = 1'b1;
         din_i = W'(xi[n]);
         din_q = W'(xq[n]);
         rdy = din_ready;
         @(posedge clk); #1;
         guard++;
         if (rdy) begin
            if (n == 0) begin
               check("busy_after_first", busy, 1);
               check("ovf_cleared", ovf, 0);
            end
            n++;
         end
      end
      check("load_accepts", n, N);
      if (!hold_valid) din_valid = 1'b0;
   endtask

   task automatic measure_compute();
      int cyc = 0;
      int rdy_hi = 0;
      while (!dout_valid && cyc < 1000) begin
         if (din_ready) rdy_hi++;
         din_i = W'($urandom);
         din_q = W'($urandom);
         @(posedge clk); #1;
         cyc++;
      end
      din_valid = 1'b0;
      check("compute_cycles", cyc, 2 * L * N);
      check("din_ready_in_compute", rdy_hi, 0);
   endtask

   // mode 0: always ready, 1: random ready, 2: ready toggling 1-0-1 every cycle
   task automatic unload(input int mode);
      int hs = 0;
      int cyc = 0;
      int last_bad = 0;
      int stab_bad = 0;
      bit pend = 1'b0;
      bit tog = 1'b1;
      logic [W-1:0] pi = '0;
      logic [W-1:0] pq = '0;
      logic pl = 1'b0;
      while (hs < N && cyc < 3000) begin
         bit r;
         case (mode)
            0: r = 1'b1;
            1: r = 1'($urandom_range(1));
            default: begin
               r = tog;
               tog = !tog;
            end
         endcase
         dout_ready = r;
         if (pend && (!dout_valid || dout_i !== pi || dout_q !== pq || dout_last !== pl)) stab_bad++;
         if (dout_valid) begin
            if (r) begin
               oi[hs] = int'($signed(dout_i));
               oq[hs] = int'($signed(dout_q));
               if (dout_last !== (hs == N - 1)) last_bad++;
               hs++;
               pend = 1'b0;
            end else begin
               pend = 1'b1;
               pi = dout_i;
               pq = dout_q;
               pl = dout_last;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      dout_ready = 1'b0;
      check("unload_handshakes", hs, N);
      check("last_only_on_final", last_bad, 0);
      check("stall_stable", stab_bad, 0);
      check("busy_after_frame", busy, 0);
      check("ready_after_frame", din_ready, 1);
   endtask

   task automatic compare(input string tag);
      for (int b = 0; b < N; b++) begin
         check($sformatf("%s_bin%0d_i", tag, b), oi[b], ei[b]);
         check($sformatf("%s_bin%0d_q", tag, b), oq[b], eq[b]);
      end
      check({tag, "_ovf"}, ovf, e_ovf);
   endtask

   task automatic set_impulse();
      for (int n = 0; n < N; n++) begin
         xi[n] = 0;
         xq[n] = 0;
      end
      xi[0] = 64;
   endtask

   task automatic set_random(input int amp);
      for (int n = 0; n < N; n++) begin
         xi[n] = int'($urandom_range(2 * amp)) - amp;
         xq[n] = int'($urandom_range(2 * amp)) - amp;
      end
   endtask

   initial begin
      din_i = '0;
      din_q = '0;
      din_valid = 1'b0;
      dout_ready = 1'b0;
      rst = 1'b0;
      for (int k = 0; k < N / 2; k++) begin
         real ang = 2.0 * 3.14159265358979 * k / N;
         rom_i[k] = clamp8(int'($cos(ang) * 128.0));
         rom_q[k] = clamp8(int'(-$sin(ang) * 128.0));
      end
      @(posedge clk); #1;
      do_reset();

      // Impulse, din_valid held through COMPUTE
      set_impulse();
      load_frame(1'b1);
      run_model();
      measure_compute();
      unload(0);
      compare("imp");
      for (int b = 0; b < N; b++) begin
         check($sformatf("imp_const_bin%0d_i", b), oi[b], IMP_BIN);
         check($sformatf("imp_const_bin%0d_q", b), oq[b], 0);
      end
      check("imp_const_ovf", ovf, 0);

      // DC of 8
      for (int n = 0; n < N; n++) begin
         xi[n] = 8;
         xq[n] = 0;
      end
      load_frame(1'b0);
      run_model();
      unload(1);
      compare("dc");
      check("dc_const_bin0", oi[0], DC_BIN0);
      for (int b = 1; b < N; b++) check($sformatf("dc_const_bin%0d", b), oi[b], 0);
      check("dc_const_ovf", ovf, DC_OVF);

      // Random frames, first one with 1-0-1 ready toggling
      for (int f = 0; f < 4; f++) begin
         set_random((f % 2 == 1) ? 127 : 20);
         load_frame(1'b0);
         run_model();
         unload((f == 0) ? 2 : 1);
         compare($sformatf("rnd%0d", f));
      end

      // Reset in the middle of COMPUTE, then a clean impulse frame
      set_random(100);
      load_frame(1'b0);
      repeat (40) @(posedge clk);
      #1;
      do_reset();
      set_impulse();
      load_frame(1'b0);
      run_model();
      unload(2);
      compare("post_rst");
      check("post_rst_bin7", oi[7], IMP_BIN);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/fft_radix2_iter.md
FFT_RADIX2_ITER -- requirements
Module: fft_radix2_iter

Interface
REQ-001 SHALL have parameter SAMPLE_WORD_LENGTH, default 8, meaning I/Q sample width in two's complement.
REQ-002 SHALL have parameter SAMPLE_FLOAT_LENGTH, default 7, meaning sample fraction bits.
REQ-003 SHALL have parameter TWIDDLE_WORD_LENGTH, default 8, meaning twiddle width.
REQ-004 SHALL have parameter TWIDDLE_FLOAT_LENGTH, default 7, meaning twiddle fraction bits.
REQ-005 SHALL have parameter LOG2_POINTS, default 4, legal 3..8, meaning transform size N = 2^LOG2_POINTS.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-low reset.
REQ-007 SHALL have ports: din_i, din_q in SAMPLE_WORD_LENGTH input sample; din_valid in 1; din_ready out 1.
REQ-008 SHALL have ports: dout_i, dout_q out SAMPLE_WORD_LENGTH result; dout_valid out 1; dout_ready in 1; dout_last out 1, marking bin N-1.
REQ-009 SHALL have ports: tw_addr out LOG2_POINTS-1 twiddle index k; tw_i, tw_q in TWIDDLE_WORD_LENGTH, equal to cos/-sin(2*pi*k/N) and valid exactly 1 cycle after tw_addr.
REQ-010 SHALL have ports: busy out 1, high outside LOAD-idle; ovf out 1, sticky overflow flag.

Function
REQ-011 SHALL implement FSM states LOAD, COMPUTE, and UNLOAD with transitions LOAD->COMPUTE after N accepted samples, COMPUTE->UNLOAD after the last butterfly write, and UNLOAD->LOAD after the dout_last handshake.
REQ-012 SHALL assert din_ready only in LOAD, accept a sample when din_valid && din_ready, and ignore din_valid in every other state.
REQ-013 SHALL write input sample n to internal memory address bitrev(n) over LOG2_POINTS bits.
REQ-014 SHALL hold busy low in LOAD until the first sample is accepted, then high until return to LOAD.
REQ-015 SHALL execute LOG2_POINTS stages s=0..L-1, each of N/2 butterflies j, in ascending j order.
REQ-016 SHALL make each butterfly occupy exactly 4 cycles (read A, read B, multiply, write A' and B'), so COMPUTE lasts 2*L*N cycles (128 for N=16).
REQ-017 SHALL compute, for stage s and butterfly j, span h=2^s, A index a=(j/h)*2h+(j mod h), B index a+h, and twiddle k=(j mod h)*2^(L-1-s).
REQ-018 SHALL compute the product B*W at full precision and round it to sample format by adding 2^(TWIDDLE_FLOAT_LENGTH-1) and then arithmetic shifting right by TWIDDLE_FLOAT_LENGTH.
REQ-019 SHALL compute A'=A+BW and B'=A-BW with one guard bit before the final word reduction defined in Configuration.
REQ-020 SHALL, in UNLOAD, present bins 0..N-1 in natural order, hold dout_* stable while dout_valid && !dout_ready, and advance only on handshake.
REQ-021 SHALL assert dout_last together with dout_valid for bin N-1 only.
REQ-022 SHALL set ovf when any reduction saturates, hold it until the first sample of the next frame is accepted, and then clear it.

Reset
REQ-023 SHALL, on rst low at any time including mid-COMPUTE or mid-UNLOAD, immediately enter LOAD and abandon the current frame.
REQ-024 SHALL, on reset, drive din_ready=1, dout_valid=0, dout_last=0, dout_i=dout_q=0, busy=0, ovf=0, tw_addr=0, and clear the sample counter.
REQ-025 SHALL leave memory contents undefined after reset and never output them before a full new frame has been loaded.

Configuration
REQ-026 SHALL define the macro FFT_STAGE_SCALE_EN; when defined, each butterfly result SHALL be arithmetic-shifted right 1 with round-half-up, so the output equals the DFT divided by N, and ovf SHALL remain 0.
REQ-027 SHALL, without FFT_STAGE_SCALE_EN, saturate each butterfly result to [-2^(W-1), 2^(W-1)-1] and set ovf on saturation.

Verification
REQ-028 SHALL verify, with N=16 and FFT_STAGE_SCALE_EN defined, that an impulse x[0]=64 with all other inputs 0 gives all 16 bins i=4, q=0, and ovf=0.
REQ-029 SHALL verify, with N=16 and no macro, that the same impulse gives all bins i=64, q=0, and ovf=0.
REQ-030 SHALL verify, with N=16 and no macro, that DC input of 16 samples of i=8 gives bin0 i=127 (saturated) and ovf=1, with bins 1..15 equal to 0; with FFT_STAGE_SCALE_EN defined, bin0 i=8.
REQ-031 SHALL verify that din_valid held high during COMPUTE results in din_ready=0, no sample accepted, and a COMPUTE duration of exactly 128 cycles.
REQ-032 SHALL verify that dout_ready toggling 1-0-1 on each cycle during UNLOAD keeps data stable while stalled, delivers 16 handshakes, and asserts dout_last only on the 16th.
REQ-033 SHALL verify that rst pulsed low mid-COMPUTE followed by a new impulse frame gives outputs matching REQ-028 or REQ-029 with no stale data.
